// File: rtl/mrv1_exec_wb_arb.sv
// ---------------------------------------------------------------------------
// mrv1_exec_wb_arb
//
// Purpose: collects results from NUM_FU_P functional units into small
// per-FU FIFOs and arbitrates them round-robin onto a single writeback port.
// Buffered results of one thread can be discarded with a flush.
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   fu_done_i/fu_rdy_o   per-FU result push handshake
//   fu_res_data_i        per-FU result data, FU i at [i*DATA_WIDTH_P +: DATA_WIDTH_P]
//   fu_itag_i            per-FU itag, same packing
//   fu_tid_i             per-FU thread id, same packing
//   wb_vld_o/wb_rdy_i    writeback handshake
//   wb_data_o, wb_itag_o, wb_tid_o, wb_fu_o   writeback payload and source FU
//   flush_vld_i, flush_tid_i                  discard all entries of one thread
//   busy_o               any FIFO non-empty
//   overflow_o           sticky: an FU pushed while its FIFO was full
//
// Handshake semantics (both interfaces): a transfer happens on a rising edge
// where valid and ready are both 1. fu_rdy_o depends only on registered
// state. Once wb_vld_o is raised with a payload, that payload and wb_fu_o
// stay stable until the transfer, unless a flush invalidates the entry.
// ---------------------------------------------------------------------------
module mrv1_exec_wb_arb #(
    parameter int NUM_THREADS_P = 8,
    parameter int DATA_WIDTH_P  = 32,
    parameter int ITAG_WIDTH_P  = 3,
    parameter int NUM_FU_P      = 6,
    parameter int FIFO_DEPTH_P  = 2,
    localparam int tid_width_lp = $clog2(NUM_THREADS_P),
    localparam int fu_width_lp  = $clog2(NUM_FU_P)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NUM_FU_P-1:0]                  fu_done_i,
    output logic [NUM_FU_P-1:0]                  fu_rdy_o,
    input  logic [NUM_FU_P*DATA_WIDTH_P-1:0]     fu_res_data_i,
    input  logic [NUM_FU_P*ITAG_WIDTH_P-1:0]     fu_itag_i,
    input  logic [NUM_FU_P*tid_width_lp-1:0]     fu_tid_i,
    output logic                                 wb_vld_o,
    input  logic                                 wb_rdy_i,
    output logic [DATA_WIDTH_P-1:0]              wb_data_o,
    output logic [ITAG_WIDTH_P-1:0]              wb_itag_o,
    output logic [tid_width_lp-1:0]              wb_tid_o,
    output logic [fu_width_lp-1:0]               wb_fu_o,
    input  logic                                 flush_vld_i,
    input  logic [tid_width_lp-1:0]              flush_tid_i,
    output logic                                 busy_o,
    output logic                                 overflow_o
);

    localparam int ptr_width_lp = (FIFO_DEPTH_P > 1) ? $clog2(FIFO_DEPTH_P) : 1;
    localparam int cnt_width_lp = $clog2(FIFO_DEPTH_P + 1);

    // Per-FU FIFO storage
    logic                      r_valid [NUM_FU_P][FIFO_DEPTH_P];
    logic [DATA_WIDTH_P-1:0]   r_data  [NUM_FU_P][FIFO_DEPTH_P];
    logic [ITAG_WIDTH_P-1:0]   r_itag  [NUM_FU_P][FIFO_DEPTH_P];
    logic [tid_width_lp-1:0]   r_tid   [NUM_FU_P][FIFO_DEPTH_P];
    logic [ptr_width_lp-1:0]   r_rptr  [NUM_FU_P];
    logic [ptr_width_lp-1:0]   r_wptr  [NUM_FU_P];
    logic [cnt_width_lp-1:0]   r_cnt   [NUM_FU_P];

    // Arbiter state
    logic [fu_width_lp-1:0]    r_rr_ptr;
    logic                      r_lock;
    logic [fu_width_lp-1:0]    r_lock_fu;
    logic                      r_overflow;

    logic [NUM_FU_P-1:0]       w_head_vld;
    logic [NUM_FU_P-1:0]       w_head_dead;
    logic [NUM_FU_P-1:0]       w_push;
    logic [NUM_FU_P-1:0]       w_pop;
    logic [fu_width_lp-1:0]    w_rr_grant;
    logic [fu_width_lp-1:0]    w_grant;
    logic [fu_width_lp-1:0]    w_rr_next;
    logic                      w_hs;

    // Head status and push qualification
    always_comb begin
        fu_rdy_o    = '0;
        w_head_vld  = '0;
        w_head_dead = '0;
        w_push      = '0;
        busy_o      = 1'b0;
        for (int i = 0; i < NUM_FU_P; i++) begin
            fu_rdy_o[i]    = (r_cnt[i] < cnt_width_lp'(FIFO_DEPTH_P));
            w_head_vld[i]  = (r_cnt[i] != '0) &&  r_valid[i][r_rptr[i]];
            // Flushed entries at the head are retired silently, one per cycle
            w_head_dead[i] = (r_cnt[i] != '0) && !r_valid[i][r_rptr[i]];
            // A push of the thread being flushed this cycle is simply dropped
            w_push[i]      = fu_done_i[i] && fu_rdy_o[i] &&
                             !(flush_vld_i &&
                               (fu_tid_i[i*tid_width_lp +: tid_width_lp] == flush_tid_i));
            busy_o         = busy_o | (r_cnt[i] != '0);
        end
    end

    // Round-robin search starting at r_rr_ptr, wrapping at NUM_FU_P
    always_comb begin
        int  j;
        logic found;
        j          = 0;
        found      = 1'b0;
        w_rr_grant = '0;
        for (int k = 0; k < NUM_FU_P; k++) begin
            j = int'(r_rr_ptr) + k;
            if (j >= NUM_FU_P) j = j - NUM_FU_P;
            if (!found && w_head_vld[j]) begin
                found      = 1'b1;
                w_rr_grant = fu_width_lp'(j);
            end
        end
    end

    // A stalled grant is held; the lock is only ever set on a valid head,
    // and that head cannot change until it is popped or the lock is dropped.
    assign w_grant  = r_lock ? r_lock_fu : w_rr_grant;
    assign wb_vld_o = |w_head_vld;
    assign wb_fu_o  = w_grant;
    assign w_hs     = wb_vld_o && wb_rdy_i;
    assign w_rr_next = (w_grant == fu_width_lp'(NUM_FU_P - 1)) ? '0
                                                                : w_grant + fu_width_lp'(1);

    always_comb begin
        wb_data_o = '0;
        wb_itag_o = '0;
        wb_tid_o  = '0;
        w_pop     = '0;
        for (int i = 0; i < NUM_FU_P; i++) begin
            if (i == int'(w_grant)) begin
                wb_data_o = r_data[i][r_rptr[i]];
                wb_itag_o = r_itag[i][r_rptr[i]];
                wb_tid_o  = r_tid[i][r_rptr[i]];
            end
            w_pop[i] = (w_hs && (i == int'(w_grant))) || w_head_dead[i];
        end
    end

    assign overflow_o = r_overflow;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_FU_P; i++) begin
                r_cnt[i]  <= '0;
                r_rptr[i] <= '0;
                r_wptr[i] <= '0;
                for (int d = 0; d < FIFO_DEPTH_P; d++) begin
                    r_valid[i][d] <= 1'b0;
                end
            end
            r_rr_ptr   <= '0;
            r_lock     <= 1'b0;
            r_lock_fu  <= '0;
            r_overflow <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_FU_P; i++) begin
                // Order matters: flush clear, then pop clear, then push set.
                // A push never targets the head slot of a non-empty FIFO.
                for (int d = 0; d < FIFO_DEPTH_P; d++) begin
                    if (flush_vld_i && (r_tid[i][d] == flush_tid_i)) begin
                        r_valid[i][d] <= 1'b0;
                    end
                end
                if (w_pop[i]) begin
                    r_valid[i][r_rptr[i]] <= 1'b0;
                    r_rptr[i]             <= r_rptr[i] + ptr_width_lp'(1);
                end
                if (w_push[i]) begin
                    r_valid[i][r_wptr[i]] <= 1'b1;
                    r_data[i][r_wptr[i]]  <= fu_res_data_i[i*DATA_WIDTH_P +: DATA_WIDTH_P];
                    r_itag[i][r_wptr[i]]  <= fu_itag_i[i*ITAG_WIDTH_P +: ITAG_WIDTH_P];
                    r_tid[i][r_wptr[i]]   <= fu_tid_i[i*tid_width_lp +: tid_width_lp];
                    r_wptr[i]             <= r_wptr[i] + ptr_width_lp'(1);
                end
                case ({w_push[i], w_pop[i]})
                    2'b10:   r_cnt[i] <= r_cnt[i] + cnt_width_lp'(1);
                    2'b01:   r_cnt[i] <= r_cnt[i] - cnt_width_lp'(1);
                    default: r_cnt[i] <= r_cnt[i];
                endcase
                if (fu_done_i[i] && !fu_rdy_o[i]) begin
                    r_overflow <= 1'b1;
                end
            end

            if (w_hs) begin
                r_rr_ptr <= w_rr_next;
                r_lock   <= 1'b0;
            end else if (wb_vld_o) begin
                // A flush hitting the stalled entry releases the grant
                if (flush_vld_i && (wb_tid_o == flush_tid_i)) begin
                    r_lock <= 1'b0;
                end else begin
                    r_lock    <= 1'b1;
                    r_lock_fu <= w_grant;
                end
            end else begin
                r_lock <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mrv1_exec_wb_arb.sv
// ---------------------------------------------------------------------------
// tb_mrv1_exec_wb_arb
//
// Directed bench for mrv1_exec_wb_arb with default parameters. Expected
// writebacks {fu, tid, itag, data} are queued in hand-computed order when
// stimulus is issued; a monitor on the falling edge pops and compares on
// every writeback handshake.
// ---------------------------------------------------------------------------
module tb_mrv1_exec_wb_arb;

    localparam int NF  = 6;
    localparam int DW  = 32;
    localparam int IW  = 3;
    localparam int TW  = 3;
    localparam int FW  = 3;
    localparam int W   = FW + TW + IW + DW;

    logic               clk;
    logic               rst_i;
    logic [NF-1:0]      fu_done;
    logic [NF-1:0]      fu_rdy;
    logic [NF*DW-1:0]   fu_data;
    logic [NF*IW-1:0]   fu_itag;
    logic [NF*TW-1:0]   fu_tid;
    logic               wb_vld;
    logic               wb_rdy;
    logic [DW-1:0]      wb_data;
    logic [IW-1:0]      wb_itag;
    logic [TW-1:0]      wb_tid;
    logic [FW-1:0]      wb_fu;
    logic               flush_vld;
    logic [TW-1:0]      flush_tid;
    logic               busy;
    logic               overflow;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    mrv1_exec_wb_arb dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .fu_done_i     (fu_done),
        .fu_rdy_o      (fu_rdy),
        .fu_res_data_i (fu_data),
        .fu_itag_i     (fu_itag),
        .fu_tid_i      (fu_tid),
        .wb_vld_o      (wb_vld),
        .wb_rdy_i      (wb_rdy),
        .wb_data_o     (wb_data),
        .wb_itag_o     (wb_itag),
        .wb_tid_o      (wb_tid),
        .wb_fu_o       (wb_fu),
        .flush_vld_i   (flush_vld),
        .flush_tid_i   (flush_tid),
        .busy_o        (busy),
        .overflow_o    (overflow)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Driver tasks: inputs change 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic clr();
        fu_done = '0;
    endtask

    task automatic put(input int fu, input logic [DW-1:0] d, input logic [IW-1:0] it,
                       input logic [TW-1:0] t);
        fu_done[fu]          = 1'b1;
        fu_data[fu*DW +: DW] = d;
        fu_itag[fu*IW +: IW] = it;
        fu_tid[fu*TW +: TW]  = t;
    endtask

    task automatic expect_wb(input logic [FW-1:0] fu, input logic [TW-1:0] t,
                             input logic [IW-1:0] it, input logic [DW-1:0] d);
        exp_q.push_back({fu, t, it, d});
    endtask

    task automatic reset_dut();
        rst_i     = 1'b1;
        wb_rdy    = 1'b0;
        flush_vld = 1'b0;
        flush_tid = '0;
        clr();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst_i && wb_vld && wb_rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected act=%0h exp=none", {wb_fu, wb_tid, wb_itag, wb_data});
            end else begin
                chk("wb_payload", 64'({wb_fu, wb_tid, wb_itag, wb_data}), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rst_i   = 1'b1;
        fu_done = '0;
        fu_data = '0;
        fu_itag = '0;
        fu_tid  = '0;
        wb_rdy  = 1'b0;
        flush_vld = 1'b0;
        flush_tid = '0;
        tick();
        reset_dut();

        // Reset state
        mid();
        chk("rst_vld", 64'(wb_vld), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rdy", 64'(fu_rdy), 64'h3f);
        chk("rst_ovf", 64'(overflow), 64'd0);
        tick();

        // Single push, one-cycle latency
        wb_rdy = 1'b1;
        put(2, 32'hA5, 3'd3, 3'd5);
        expect_wb(3'd2, 3'd5, 3'd3, 32'hA5);
        mid();
        chk("a_no_bypass", 64'(wb_vld), 64'd0);
        tick();
        clr();
        mid();
        chk("a_vld", 64'(wb_vld), 64'd1);
        chk("a_fu", 64'(wb_fu), 64'd2);
        tick();
        mid();
        chk("a_busy", 64'(busy), 64'd0);
        chk("a_vld_after", 64'(wb_vld), 64'd0);
        drain("a_drain");

        // Round robin order 0,1,4 then continuing from 5 with wrap
        reset_dut();
        wb_rdy = 1'b1;
        put(0, 32'h100, 3'd0, 3'd0);
        put(1, 32'h101, 3'd1, 3'd1);
        put(4, 32'h104, 3'd4, 3'd4);
        expect_wb(3'd0, 3'd0, 3'd0, 32'h100);
        expect_wb(3'd1, 3'd1, 3'd1, 32'h101);
        expect_wb(3'd4, 3'd4, 3'd4, 32'h104);
        tick();
        clr();
        mid(); chk("b_fu0", 64'(wb_fu), 64'd0); tick();
        mid(); chk("b_fu1", 64'(wb_fu), 64'd1); tick();
        mid(); chk("b_fu4", 64'(wb_fu), 64'd4); tick();
        mid(); chk("b_idle", 64'(wb_vld), 64'd0); tick();
        put(0, 32'h200, 3'd2, 3'd7);
        put(3, 32'h203, 3'd5, 3'd6);
        put(5, 32'h205, 3'd6, 3'd1);
        expect_wb(3'd5, 3'd1, 3'd6, 32'h205);
        expect_wb(3'd0, 3'd7, 3'd2, 32'h200);
        expect_wb(3'd3, 3'd6, 3'd5, 32'h203);
        tick();
        clr();
        mid(); chk("b_fu5", 64'(wb_fu), 64'd5); tick();
        mid(); chk("b_wrap0", 64'(wb_fu), 64'd0); tick();
        mid(); chk("b_fu3", 64'(wb_fu), 64'd3); tick();
        drain("b_drain");

        // Grant locked while stalled
        reset_dut();
        put(3, 32'h33, 3'd1, 3'd3);
        expect_wb(3'd3, 3'd3, 3'd1, 32'h33);
        tick();
        clr();
        put(0, 32'h10, 3'd2, 3'd0);
        expect_wb(3'd0, 3'd0, 3'd2, 32'h10);
        mid();
        chk("c_vld", 64'(wb_vld), 64'd1);
        chk("c_fu_first", 64'(wb_fu), 64'd3);
        tick();
        clr();
        for (int k = 0; k < 3; k++) begin
            mid();
            chk("c_fu_hold", 64'(wb_fu), 64'd3);
            chk("c_data_hold", 64'(wb_data), 64'h33);
            tick();
        end
        wb_rdy = 1'b1;
        mid(); chk("c_fu_hs", 64'(wb_fu), 64'd3); tick();
        mid(); chk("c_fu_next", 64'(wb_fu), 64'd0); tick();
        drain("c_drain");

        // Full FIFO and overflow
        reset_dut();
        put(1, 32'hD1, 3'd4, 3'd1);
        expect_wb(3'd1, 3'd1, 3'd4, 32'hD1);
        tick();
        clr();
        put(1, 32'hD2, 3'd5, 3'd2);
        expect_wb(3'd1, 3'd2, 3'd5, 32'hD2);
        mid();
        chk("d_rdy_one", 64'(fu_rdy[1]), 64'd1);
        tick();
        clr();
        put(1, 32'hBAD, 3'd6, 3'd3);
        mid();
        chk("d_rdy_full", 64'(fu_rdy[1]), 64'd0);
        chk("d_ovf_pre", 64'(overflow), 64'd0);
        tick();
        clr();
        wb_rdy = 1'b1;
        put(1, 32'hBAD2, 3'd7, 3'd4);
        mid();
        chk("d_ovf_set", 64'(overflow), 64'd1);
        chk("d_rdy_still_full", 64'(fu_rdy[1]), 64'd0);
        tick();
        clr();
        drain("d_drain");
        tick();
        mid();
        chk("d_ovf_sticky", 64'(overflow), 64'd1);
        chk("d_rdy_all", 64'(fu_rdy), 64'h3f);
        chk("d_busy", 64'(busy), 64'd0);
        tick();

        // Reset with three entries buffered
        wb_rdy = 1'b0;
        put(0, 32'hE0, 3'd0, 3'd0);
        put(1, 32'hE1, 3'd1, 3'd1);
        put(2, 32'hE2, 3'd2, 3'd2);
        tick();
        clr();
        mid();
        chk("f_busy_pre", 64'(busy), 64'd1);
        chk("f_vld_pre", 64'(wb_vld), 64'd1);
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        mid();
        chk("f_vld", 64'(wb_vld), 64'd0);
        chk("f_busy", 64'(busy), 64'd0);
        chk("f_ovf", 64'(overflow), 64'd0);
        chk("f_rdy", 64'(fu_rdy), 64'h3f);
        tick();

        // Flush of one thread, same-cycle push of that thread dropped
        reset_dut();
        put(0, 32'h22, 3'd1, 3'd2);
        tick();
        clr();
        put(0, 32'h66, 3'd2, 3'd6);
        tick();
        clr();
        flush_vld = 1'b1;
        flush_tid = 3'd2;
        put(5, 32'h55, 3'd3, 3'd2);
        expect_wb(3'd0, 3'd6, 3'd2, 32'h66);
        mid();
        chk("e_rdy0_full", 64'(fu_rdy[0]), 64'd0);
        chk("e_fu_locked", 64'(wb_fu), 64'd0);
        tick();
        clr();
        flush_vld = 1'b0;
        mid();
        chk("e_vld_dead_head", 64'(wb_vld), 64'd0);
        chk("e_cnt_kept", 64'(fu_rdy[0]), 64'd0);
        tick();
        wb_rdy = 1'b1;
        mid();
        chk("e_vld", 64'(wb_vld), 64'd1);
        chk("e_tid", 64'(wb_tid), 64'd6);
        chk("e_ovf", 64'(overflow), 64'd0);
        tick();
        drain("e_drain");
        tick();
        mid();
        chk("e_busy", 64'(busy), 64'd0);
        chk("e_vld_end", 64'(wb_vld), 64'd0);
        tick();

        chk("final_queue", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mrv1_exec_wb_arb.md
MRV1_EXEC_WB_ARB -- requirements
Module: mrv1_exec_wb_arb

Interface
REQ-001 SHALL have parameter NUM_THREADS_P, default 8, thread count; tid_width_lp = $clog2(NUM_THREADS_P).
REQ-002 SHALL have parameter DATA_WIDTH_P, default 32, result width.
REQ-003 SHALL have parameter ITAG_WIDTH_P, default 3, instruction tag width.
REQ-004 SHALL have parameter NUM_FU_P, default 6, functional-unit count (>=2); fu_width_lp = $clog2(NUM_FU_P).
REQ-005 SHALL have parameter FIFO_DEPTH_P, default 2, per-FU result buffer depth (power of 2, >=2).
REQ-006 SHALL have clk_i  input  1  single clock, all state on rising edge.
REQ-007 SHALL have rst_i  input  1  reset, synchronous, active-high.
REQ-008 SHALL have fu_done_i  input  NUM_FU_P  per-FU result valid.
REQ-009 SHALL have fu_rdy_o  output  NUM_FU_P  per-FU buffer can accept.
REQ-010 SHALL have fu_res_data_i  input  NUM_FU_P x DATA_WIDTH_P  per-FU result.
REQ-011 SHALL have fu_itag_i  input  NUM_FU_P x ITAG_WIDTH_P  per-FU itag.
REQ-012 SHALL have fu_tid_i  input  NUM_FU_P x tid_width_lp  per-FU thread id.
REQ-013 SHALL have wb_vld_o / wb_rdy_i  output / input  1 / 1  writeback handshake.
REQ-014 SHALL have wb_data_o, wb_itag_o, wb_tid_o, wb_fu_o  output  DATA_WIDTH_P, ITAG_WIDTH_P, tid_width_lp, fu_width_lp  writeback payload and source FU index.
REQ-015 SHALL have flush_vld_i, flush_tid_i  input  1, tid_width_lp  discard all buffered results of one thread.
REQ-016 SHALL have busy_o  output  1  any buffer entry occupied; overflow_o  output  1  sticky protocol-error flag.

Function
REQ-017 SHALL keep one FIFO of FIFO_DEPTH_P entries per FU, each entry {valid, data, itag, tid}, with count register 0..FIFO_DEPTH_P.
REQ-018 SHALL drive fu_rdy_o[i] = (count[i] < FIFO_DEPTH_P), from registered state only; no combinational path from wb_rdy_i or flush_vld_i.
REQ-019 SHALL push when fu_done_i[i] && fu_rdy_o[i]; full FIFO accepts no push even if popped the same cycle.
REQ-020 SHALL ignore fu_done_i[i] while fu_rdy_o[i]=0 and set overflow_o=1 until reset.
REQ-021 SHALL make a pushed entry visible on wb at earliest the next cycle (1-cycle min latency, no bypass).
REQ-022 SHALL assert wb_vld_o combinationally when any FIFO head is valid; payload taken from granted head.
REQ-023 SHALL grant round-robin: first FU with valid head at index >= rr_ptr, wrapping; after handshake rr_ptr <= (grant+1) mod NUM_FU_P.
REQ-024 SHALL lock the grant while wb_vld_o && !wb_rdy_i; payload and wb_fu_o stay stable until handshake.
REQ-025 SHALL pop the granted head and decrement its count on wb_vld_o && wb_rdy_i.
REQ-026 SHALL, on flush_vld_i, clear valid on every buffered entry with tid == flush_tid_i at end of cycle; count unchanged.
REQ-027 SHALL drop a same-cycle push whose fu_tid_i == flush_tid_i while flush_vld_i (no entry written, no overflow).
REQ-028 SHALL complete a handshake occurring in the flush cycle normally (entry counts as written back); lock released by flush if locked entry invalidated.
REQ-029 SHALL auto-pop invalid heads one per FU per cycle without presenting them on wb, decrementing count.
REQ-030 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH_P.
REQ-031 SHALL drive busy_o = OR of all counts nonzero.

Reset
REQ-032 SHALL on rst_i=1 clear all counts, pointers, valid bits, rr_ptr (0), lock, overflow_o; wb_vld_o=0, busy_o=0, fu_rdy_o all 1 from next cycle; reset mid-handshake discards all entries.

Verification
REQ-033 SHALL cover: push FU2 data 0xA5, itag 3, tid 5 at cycle 0, wb_rdy_i=1 -> wb_vld_o=1 at cycle 1 with 0xA5/3/5, wb_fu_o=2; busy_o=0 at cycle 2.
REQ-034 SHALL cover: FUs 0,1,4 push same cycle, wb_rdy_i=1 -> writebacks in order 0,1,4 on consecutive cycles; next arbitration starts at 5.
REQ-035 SHALL cover: wb_rdy_i=0, FU3 pending, FU0 pushes later -> wb_fu_o stays 3 until wb_rdy_i=1.
REQ-036 SHALL cover: FU1 two pushes (DEPTH 2), wb_rdy_i=0 -> fu_rdy_o[1]=0; third fu_done_i[1] -> overflow_o=1, no entry added.
REQ-037 SHALL cover: FU0 holds tid 2 then tid 6, flush tid 2 -> only tid 6 entry written back; simultaneous FU5 push tid 2 dropped.
REQ-038 SHALL cover: rst_i asserted with 3 entries buffered -> next cycle wb_vld_o=0, busy_o=0, overflow_o=0, fu_rdy_o=all 1s.
